calc_instr_issue: RTL and testbench

Instruction issue queue placed directly upstream of `calculator_design`. It buffers packed 32-bit four-operand instructions from a producer over a valid/ready handshake. It presents them to the calculator's `instruction` input one per accepted cycle, in order, and tags each issued instruction with a wrapping sequence number so that result checkers can align the calculator's 8-bit `result` with its source instruction.

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_fifo_mem.sv | 24 ++
 rtl/calc_instr_issue.sv | 97 +++++++++
 tb/tb_calc_instr_issue.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator instruction path: operand width,
// the packed four-operand instruction and the sequence tag type.
package calc_pkg;

  localparam int OPERAND_W = 8;
  localparam int SEQ_W     = 8;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [OPERAND_W-1:0] c;
    logic [OPERAND_W-1:0] d;
  } calc_instr_t;

  typedef logic [SEQ_W-1:0] calc_seq_t;

endpackage

// File: rtl/calc_fifo_mem.sv
// Register-array storage for the issue queue: one synchronous write port
// and one asynchronous read port. Contents are deliberately never cleared.
module calc_fifo_mem #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 40,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/calc_instr_issue.sv
// Instruction issue queue ahead of the calculator: in-order buffering with a
// wrapping sequence tag per entry and zero-fill of the output when empty.
module calc_instr_issue
  import calc_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int OPERAND_W = calc_pkg::OPERAND_W,
  parameter int SEQ_W     = calc_pkg::SEQ_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*OPERAND_W-1:0]     in_instr,
  output logic [4*OPERAND_W-1:0]     instruction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEQ_W-1:0]           seq,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int INSTR_W = 4 * OPERAND_W;
  localparam int ENT_W   = SEQ_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [SEQ_W-1:0] wr_seq_q, wr_seq_d;
  logic [ENT_W-1:0] head_ent;
  logic             push, pop;

  // in_ready never looks at out_ready, so a full queue refuses a push even
  // when the head is leaving in the same cycle.
  assign in_ready  = (count_q < DEPTH_C) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_seq_d = wr_seq_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        wr_seq_d = wr_seq_q + SEQ_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_seq_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_seq_q <= wr_seq_d;
    end
  end

  calc_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data ({wr_seq_q, in_instr}),
    .rd_addr (rd_ptr_q),
    .rd_data (head_ent)
  );

  // Stale memory is masked; an empty queue advertises the next tag to be issued.
  assign instruction = out_valid ? head_ent[INSTR_W-1:0] : '0;
  assign seq         = out_valid ? head_ent[ENT_W-1 -: SEQ_W] : wr_seq_q;
  assign count       = count_q;

endmodule

// File: tb/tb_calc_instr_issue.sv
// Randomised bench for calc_instr_issue against a queue-based reference model.
module tb_calc_instr_issue;
  import calc_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  seq;
  logic [3:0]  count;

  calc_instr_issue #(.DEPTH(DEPTH), .OPERAND_W(8), .SEQ_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .seq         (seq),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] instr;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] m_wr_seq = 8'd0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic fl);
    int sz;
    sz = mq.size();
    chk("in_ready",    64'(in_ready),    64'((sz < DEPTH) && !fl));
    chk("out_valid",   64'(out_valid),   64'(sz != 0));
    chk("instruction", 64'(instruction), (sz != 0) ? 64'(mq[0].instr) : 64'd0);
    chk("seq",         64'(seq),         (sz != 0) ? 64'(mq[0].tag) : 64'(m_wr_seq));
    chk("count",       64'(count),       64'(sz));
  endtask

  // Called just after a rising edge; applies inputs for one cycle.
  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    logic do_push, do_pop;
    ent_t e;
    in_valid = v; in_instr = d; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_outputs(fl);
    do_push = v && (mq.size() < DEPTH) && !fl;
    do_pop  = (mq.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.tag = m_wr_seq; e.instr = d;
        mq.push_back(e);
        m_wr_seq = m_wr_seq + 8'd1;
      end
    end
    #1;
  endtask

  initial begin
    calc_instr_t ci;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    reset = 1'b0;

    repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 32'h01020304, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("single_seq", 64'(seq), 64'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    for (int k = 1; k <= 8; k++) begin
      ci.a = 8'(k); ci.b = 8'(2*k); ci.c = 8'(3*k); ci.d = 8'(4*k);
      cycle(1'b1, ci, 1'b0, 1'b0);
    end
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd8);
    cycle(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    repeat (9) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    repeat (300) cycle(1'b1, $urandom, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    repeat (3) cycle(1'b1, $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    m_wr_seq = 8'd0;
    chk("arst_out_valid", 64'(out_valid),   64'd0);
    chk("arst_count",     64'(count),       64'd0);
    chk("arst_instr",     64'(instruction), 64'd0);
    chk("arst_seq",       64'(seq),         64'd0);
    chk("arst_in_ready",  64'(in_ready),    64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 32'h0A0B0C0D, 1'b0, 1'b0);
    chk("post_rst_tag", 64'(seq), 64'd0);
    repeat (4) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h11111111, 1'b1, 1'b1);
    cycle(1'b1, 32'h22222222, 1'b0, 1'b0);
    chk("post_flush_tag", 64'(seq), 64'd5);

    for (int i = 0; i < 600; i++)
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
